// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampled UART receiver with valid/ready holding register and error flags
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic [15:0]           baud_div,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  overrun_err,
  output logic                  busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [SW-1:0] SMAX  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SHALF = SW'(OVERSAMPLE / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic rx_m, rx_s, rx_q;
  logic [15:0] cnt, div_q;
  logic [SW-1:0] sub;
  logic [IW-1:0] idx;
  logic stp;
  logic [DATA_WIDTH-1:0] shift;
  logic pe, fe;
  logic fall, tick, drain;
  assign fall  = (state == IDLE) && rx_q && !rx_s;
  assign tick  = cnt == div_q - 16'd1;
  assign drain = rx_valid && rx_ready;
  assign busy  = state != IDLE;
  // two-flop synchronizer plus previous-value register for edge detection
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end
  // oversample tick counter, realigned to the start edge; divisor latched at each wrap
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      cnt   <= 16'd0;
      div_q <= 16'd1;
    end else if (fall || tick) begin
      cnt   <= 16'd0;
      div_q <= (baud_div == 16'd0) ? 16'd1 : baud_div;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
  // frame FSM with registered holding register, flags and overrun pulse
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state       <= IDLE;
      sub         <= '0;
      idx         <= '0;
      stp         <= 1'b0;
      shift       <= '0;
      pe          <= 1'b0;
      fe          <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (drain) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
      end
      case (state)
        IDLE: if (fall) begin
          state <= START;
          sub   <= '0;
          idx   <= '0;
          stp   <= 1'b0;
          pe    <= 1'b0;
          fe    <= 1'b0;
        end
        START: if (tick) begin
          if (sub == SHALF) begin
            sub   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else sub <= sub + 1'b1;
        end
        DATA: if (tick) begin
          if (sub == SMAX) begin
            sub   <= '0;
            shift <= {rx_s, shift[DATA_WIDTH-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IW'(DATA_WIDTH - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else sub <= sub + 1'b1;
        end
        PARITY: if (tick) begin
          if (sub == SMAX) begin
            sub   <= '0;
            pe    <= (^shift ^ rx_s) != (PARITY_ODD != 0);
            state <= STOP;
          end else sub <= sub + 1'b1;
        end
        STOP: if (tick) begin
          if (sub == SMAX) begin
            sub <= '0;
            fe  <= fe | ~rx_s;
            stp <= stp + 1'b1;
            if (stp == 1'(STOP_BITS - 1)) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data     <= shift;
                rx_valid    <= 1'b1;
                parity_err  <= pe;
                framing_err <= fe | ~rx_s;
              end else overrun_err <= 1'b1;
            end
          end else sub <= sub + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive-side stage that consumes the serial rx line carried on the UART pin interface and converts each asynchronous frame into a parallel data word with error flags.
- Generates its own 16x-oversample tick from pclk using a runtime baud divisor.
- Hands words downstream over a single-entry valid/ready holding register.
- Sits between the UART pin interface (rx) and the receive-side monitor/FIFO logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame (legal 5..8), LSB first.
- OVERSAMPLE, 16, ticks per bit period (even, >=4).
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits checked (1 or 2).

Ports:
- pclk  input  1  system clock.
- areset  input  1  asynchronous active-low reset.
- baud_div  input  16  pclk cycles per oversample tick; 0 is treated as 1.
- rx  input  1  serial receive line, idle high, asynchronous to pclk.
- rx_data  output  DATA_WIDTH  received word.
- rx_valid  output  1  rx_data and error flags are valid.
- rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
- parity_err  output  1  parity mismatch on the held word.
- framing_err  output  1  a stop bit was sampled low for the held word.
- overrun_err  output  1  one-cycle pulse: a frame completed while the holding register was full.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (areset=0, asynchronous): all outputs 0, synchronizer flops 1, tick counter 0, FSM = IDLE. Reset mid-frame discards the partial frame.
- Synchronizer: rx passes through a 2-flop synchronizer, then a 1-flop previous-value register (rx_s, rx_q).
- Tick generator: counter runs 0..max(baud_div,1)-1 and asserts tick for one pclk at the terminal count. The counter is cleared on the falling-edge detect in IDLE, so sampling phase is aligned to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge (rx_q=1, rx_s=0) goes to START; the sub-tick counter is cleared. A line held low does not retrigger.
  - START: after OVERSAMPLE/2 ticks, sample rx_s. If 0, go to DATA with bit index 0. If 1 (glitch), return to IDLE with no output.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift bit[index], LSB first. After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: after OVERSAMPLE ticks, sample. Error if XOR(data, sample) != PARITY_ODD.
  - STOP: sample each stop bit every OVERSAMPLE ticks. Any low sample sets the framing flag. After the last stop sample, commit and go to IDLE in the same cycle.
- Commit: the cycle after the final stop sample, one of the following applies.
  - Holding register empty, or being drained this cycle (rx_valid && rx_ready): load rx_data, parity_err, framing_err; rx_valid=1.
  - Holding register full and not draining: drop the new frame, keep the old word and flags, pulse overrun_err for 1 cycle.
- Handshake: rx_valid stays high and rx_data/flags stay stable until accepted. On acceptance without a simultaneous commit, rx_valid=0 next cycle and the flags clear to 0.
- Framing-error frames are still delivered (data as sampled, framing_err=1). After a break (all zeros), a new start requires rx to return high and then fall.
- Latency: rx_valid rises 1 pclk after the final stop-bit mid-sample tick. The synchronizer adds 2 pclk to all edge timing.
- baud_div changes take effect at the next tick-counter wrap. Changing it mid-frame is not supported; data is undefined but the FSM must still return to IDLE.

Test Plan:
- Nominal frame: baud_div=4 (64 pclk/bit), default params, send 0xA5 with 1 stop, rx_ready=1 -> rx_valid pulses once, rx_data=0xA5, parity_err=0, framing_err=0, busy low after the frame.
- Glitch rejection: rx low for 20 pclk, then high (shorter than the 32-pclk half bit) -> no rx_valid, FSM back in IDLE, busy deasserted.
- Framing/break: send 0x00 with the stop bit low and the line held low 3 bit times, then high, then frame 0x3C -> first word 0x00 with framing_err=1, exactly one further word 0x3C with framing_err=0.
- Parity (PARITY_EN=1, PARITY_ODD=0): send 0x07 with parity bit 1 -> parity_err=0. Same data with parity bit 0 -> parity_err=1, rx_data=0x07.
- Overrun and simultaneous drain: rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses 1 cycle. Repeat with rx_ready asserted on the exact commit cycle of 0x22 -> rx_data=0x22, no overrun, rx_valid stays high.
- Reset mid-frame: assert areset low during data bit 3 of 0xF0, release, then send 0x5A -> no output for 0xF0, outputs 0 during reset, single word 0x5A.
